// File: rtl/colorizer_pipe.sv
// Pixel colorizer: aligns syncs with map/icon data, looks up a
// double-buffered palette and blinks the icon overlay per frame.
module colorizer_pipe #(
  parameter int SYNC_DLY     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  world_pixel,
  input  logic [1:0]  icon,
  input  logic        blink_en,
  input  logic        pal_we,
  input  logic [2:0]  pal_addr,
  input  logic [11:0] pal_data,
  output logic        pal_pending,
  output logic        video_on_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [11:0] rgb
);

  typedef enum logic [1:0] {
    SOLID = 2'd0,
    SHOW  = 2'd1,
    HIDE  = 2'd2
  } blink_e;

  logic [SYNC_DLY-1:0] von_sr_q, von_sr_d;
  logic [SYNC_DLY-1:0] hs_sr_q, hs_sr_d;
  logic [SYNC_DLY-1:0] vs_sr_q, vs_sr_d;
  logic                von_dly, hs_dly, vs_dly;
  logic                vs_prev_q;
  logic                frame_edge;

  logic                von_out_q, hs_out_q, vs_out_q;
  logic [11:0]         rgb_q, rgb_d;
  logic                pend_q, pend_d;

  logic [11:0]         shadow_q [8];
  logic [11:0]         active_q [8];

  blink_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;

  function automatic logic [11:0] pal_rst(input int idx);
    case (idx)
      0:       pal_rst = 12'hFFF;
      2:       pal_rst = 12'hF00;
      3:       pal_rst = 12'h00F;
      5:       pal_rst = 12'h0F0;
      6:       pal_rst = 12'hFF0;
      7:       pal_rst = 12'hF0F;
      default: pal_rst = 12'h000;
    endcase
  endfunction

  assign von_sr_d = SYNC_DLY'({von_sr_q, video_on});
  assign hs_sr_d  = SYNC_DLY'({hs_sr_q, hsync_in});
  assign vs_sr_d  = SYNC_DLY'({vs_sr_q, vsync_in});

  assign von_dly = von_sr_q[SYNC_DLY-1];
  assign hs_dly  = hs_sr_q[SYNC_DLY-1];
  assign vs_dly  = vs_sr_q[SYNC_DLY-1];

  assign frame_edge = vs_prev_q & ~vs_dly;

  // A write landing on a boundary cycle still counts as pending
  assign pend_d = pal_we ? 1'b1 : (frame_edge ? 1'b0 : pend_q);

  always_comb begin
    rgb_d = 12'h000;
    if (von_dly) begin
      if (icon != 2'd0 && state_q != HIDE) begin
        rgb_d = active_q[{1'b1, icon}];
      end else begin
        rgb_d = active_q[{1'b0, world_pixel}];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SOLID: begin
        if (frame_edge && blink_en) begin
          state_d = SHOW;
          cnt_d   = 8'd0;
        end
      end
      SHOW, HIDE: begin
        if (!blink_en) begin
          state_d = SOLID;
          cnt_d   = 8'd0;
        end else if (frame_edge) begin
          if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
            state_d = (state_q == SHOW) ? HIDE : SHOW;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = SOLID;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      von_sr_q  <= '0;
      hs_sr_q   <= '0;
      vs_sr_q   <= '0;
      vs_prev_q <= 1'b1;
      von_out_q <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      rgb_q     <= 12'h000;
      pend_q    <= 1'b0;
      state_q   <= SOLID;
      cnt_q     <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= pal_rst(i);
        active_q[i] <= pal_rst(i);
      end
    end else begin
      von_sr_q  <= von_sr_d;
      hs_sr_q   <= hs_sr_d;
      vs_sr_q   <= vs_sr_d;
      vs_prev_q <= vs_dly;
      von_out_q <= von_dly;
      hs_out_q  <= hs_dly;
      vs_out_q  <= vs_dly;
      rgb_q     <= rgb_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (frame_edge) begin
        for (int i = 0; i < 8; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (pal_we) begin
        shadow_q[pal_addr] <= pal_data;
      end
    end
  end

  assign pal_pending  = pend_q;
  assign video_on_out = von_out_q;
  assign hsync_out    = hs_out_q;
  assign vsync_out    = vs_out_q;
  assign rgb          = rgb_q;

endmodule

// File: tb/tb_colorizer_pipe.sv
// Scoreboard bench for colorizer_pipe: directed vectors push
// expected outputs, a monitor pops and compares each cycle.
module tb_colorizer_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [1:0]  world_pixel = 2'd0;
  logic [1:0]  icon = 2'd0;
  logic        blink_en = 1'b0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_addr = 3'd0;
  logic [11:0] pal_data = 12'h000;
  logic        pal_pending;
  logic        video_on_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [11:0] rgb;

  typedef struct {
    bit          chk;
    string       name;
    logic [11:0] rgb;
    logic        von;
    logic        pend;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  colorizer_pipe #(
    .SYNC_DLY    (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .world_pixel (world_pixel),
    .icon        (icon),
    .blink_en    (blink_en),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .pal_pending (pal_pending),
    .video_on_out(video_on_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .rgb         (rgb)
  );

  // Inputs are set at a negedge; the entry describes the outputs
  // expected right after the following posedge.
  task automatic step(input bit chk, input string nm,
                      input logic [11:0] e_rgb, input logic e_von,
                      input logic e_pend, input logic e_hs,
                      input logic e_vs);
    exp_t e;
    e.chk  = chk;
    e.name = nm;
    e.rgb  = e_rgb;
    e.von  = e_von;
    e.pend = e_pend;
    e.hs   = e_hs;
    e.vs   = e_vs;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic skip();
    step(1'b0, "", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold(input int n, input string nm,
                      input logic [11:0] e_rgb, input logic e_von,
                      input logic e_pend);
    repeat (n - 1) skip();
    step(1'b1, nm, e_rgb, e_von, e_pend, 1'b1, 1'b1);
  endtask

  task automatic frame(input string nm, input logic [11:0] e_rgb,
                       input logic e_pend);
    vsync_in = 1'b0;
    skip();
    vsync_in = 1'b1;
    repeat (4) skip();
    step(1'b1, nm, e_rgb, 1'b1, e_pend, 1'b1, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          n_cmp++;
          if (rgb !== e.rgb || video_on_out !== e.von ||
              pal_pending !== e.pend || hsync_out !== e.hs ||
              vsync_out !== e.vs) begin
            n_bad++;
            $display("FAIL %s: got rgb=%h von=%b pend=%b hs=%b vs=%b, want rgb=%h von=%b pend=%b hs=%b vs=%b",
                     e.name, rgb, video_on_out, pal_pending, hsync_out,
                     vsync_out, e.rgb, e.von, e.pend, e.hs, e.vs);
          end
        end
      end
    end
  end

  logic [11:0] blink_exp [7];

  initial begin
    blink_exp[0] = 12'h0F0;
    blink_exp[1] = 12'h0F0;
    blink_exp[2] = 12'h000;
    blink_exp[3] = 12'h000;
    blink_exp[4] = 12'h0F0;
    blink_exp[5] = 12'h0F0;
    blink_exp[6] = 12'h000;

    @(negedge clk);
    skip();
    skip();
    step(1'b1, "reset", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    reset       = 1'b0;
    video_on    = 1'b1;
    world_pixel = 2'd2;
    step(1'b1, "lat0", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, "lat1", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, "lat2", 12'hF00, 1'b1, 1'b0, 1'b1, 1'b1);
    hold(4, "world2", 12'hF00, 1'b1, 1'b0);

    world_pixel = 2'd0;
    icon        = 2'd3;
    hold(4, "icon3", 12'hF0F, 1'b1, 1'b0);
    video_on = 1'b0;
    hold(4, "blank", 12'h000, 1'b0, 1'b0);
    video_on = 1'b1;
    icon     = 2'd0;
    hold(4, "world0", 12'hFFF, 1'b1, 1'b0);

    hsync_in = 1'b0;
    repeat (3) skip();
    step(1'b1, "hsync_lo", 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    hsync_in = 1'b1;
    hold(4, "hsync_hi", 12'hFFF, 1'b1, 1'b0);

    pal_we   = 1'b1;
    pal_addr = 3'd0;
    pal_data = 12'h123;
    step(1'b1, "wr_mid", 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    pal_we = 1'b0;
    hold(4, "wr_held", 12'hFFF, 1'b1, 1'b1);
    frame("wr_commit", 12'h123, 1'b0);

    world_pixel = 2'd3;
    hold(4, "world3", 12'h00F, 1'b1, 1'b0);
    vsync_in = 1'b0;
    skip();
    vsync_in = 1'b1;
    skip();
    pal_we   = 1'b1;
    pal_addr = 3'd3;
    pal_data = 12'h456;
    step(1'b1, "wr_edge", 12'h00F, 1'b1, 1'b1, 1'b1, 1'b0);
    pal_we = 1'b0;
    hold(4, "wr_edge_held", 12'h00F, 1'b1, 1'b1);
    frame("wr_edge_commit", 12'h456, 1'b0);

    world_pixel = 2'd1;
    icon        = 2'd1;
    blink_en    = 1'b1;
    hold(4, "blink_solid", 12'h0F0, 1'b1, 1'b0);
    for (int f = 0; f < 7; f++) begin
      frame($sformatf("blink_f%0d", f + 1), blink_exp[f], 1'b0);
    end
    blink_en = 1'b0;
    step(1'b1, "drop_hide", 12'h000, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, "drop_solid", 12'h0F0, 1'b1, 1'b0, 1'b1, 1'b1);

    blink_en = 1'b1;
    frame("re_show", 12'h0F0, 1'b0);
    frame("re_cnt", 12'h0F0, 1'b0);
    frame("re_hide", 12'h000, 1'b0);
    pal_we   = 1'b1;
    pal_addr = 3'd1;
    pal_data = 12'h777;
    step(1'b1, "hide_wr", 12'h000, 1'b1, 1'b1, 1'b1, 1'b1);
    pal_we = 1'b0;
    reset  = 1'b1;
    step(1'b1, "mid_reset", 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset    = 1'b0;
    blink_en = 1'b0;
    hold(5, "post_solid", 12'h0F0, 1'b1, 1'b0);
    icon        = 2'd0;
    world_pixel = 2'd3;
    hold(4, "post_pal3", 12'h00F, 1'b1, 1'b0);
    world_pixel = 2'd1;
    hold(4, "post_pal1", 12'h000, 1'b1, 1'b0);
    world_pixel = 2'd0;
    hold(4, "post_pal0", 12'hFFF, 1'b1, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #3;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/colorizer_pipe.md
COLORIZER_PIPE -- requirements
Module: colorizer_pipe

Interface
REQ-001 Parameter SYNC_DLY, default 2, cycles that video_on/hsync_in/vsync_in are delayed to align with world_pixel/icon (BRAM latency upstream); legal range 1..4.
REQ-002 Parameter BLINK_FRAMES, default 30, frames per blink phase; legal range 1..255.
REQ-003 clk  input  1  pixel clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 video_on  input  1  display-enable from timing generator, undelayed.
REQ-006 hsync_in  input  1  horizontal sync, active-low, undelayed.
REQ-007 vsync_in  input  1  vertical sync, active-low, undelayed.
REQ-008 world_pixel  input  2  map code (0 background, 1 black line, 2 obstruction, 3 reserved), already aligned to the data path.
REQ-009 icon  input  2  icon overlay code, 0 = transparent, aligned with world_pixel.
REQ-010 blink_en  input  1  level; 1 = icon blinks, 0 = icon solid.
REQ-011 pal_we  input  1  palette write strobe, one write per cycle.
REQ-012 pal_addr  input  3  palette index: 0-3 world codes, 5-7 icon codes 1-3, 4 unused.
REQ-013 pal_data  input  12  RGB 4:4:4 value to write.
REQ-014 pal_pending  output  1  1 = shadow palette holds writes not yet committed.
REQ-015 video_on_out, hsync_out, vsync_out  output  1 each  syncs aligned with rgb.
REQ-016 rgb  output  12  registered pixel colour {R[3:0],G[3:0],B[3:0]}.

Function
REQ-017 Sync path: video_on/hsync_in/vsync_in pass through a SYNC_DLY-stage shift register, then the output register; total latency SYNC_DLY+1 cycles.
REQ-018 Data path: world_pixel/icon sampled with the SYNC_DLY-delayed syncs; rgb registered 1 cycle later, aligned with *_out.
REQ-019 Colour select: if delayed video_on = 0, rgb = 12'h000; else if icon != 0 and blink state is not HIDE, rgb = active[4+icon]; else rgb = active[world_pixel].
REQ-020 Frame boundary = falling edge of the SYNC_DLY-delayed vsync (1 -> 0); edge detector's previous-value register resets to 1 so no boundary fires out of reset.
REQ-021 Palette: two 8x12 banks, shadow and active; pal_we writes shadow[pal_addr] at clock edge and sets pal_pending.
REQ-022 At a frame boundary active <= shadow (all 8 entries) and pal_pending clears; colour lookup always uses active, never shadow.
REQ-023 Write coincident with frame boundary: active takes the pre-write shadow, the new word lands in shadow, pal_pending stays 1 until the next boundary.
REQ-024 Index 4 is writable and stored but never selected by REQ-019.
REQ-025 Blink FSM states SOLID, SHOW, HIDE; 8-bit frame counter counts boundaries in SHOW/HIDE.
REQ-026 SOLID -> SHOW at the first frame boundary with blink_en = 1; counter cleared.
REQ-027 SHOW -> HIDE and HIDE -> SHOW at the boundary where counter reaches BLINK_FRAMES-1; counter cleared on each transition, else increments per boundary.
REQ-028 blink_en = 0 in SHOW or HIDE -> SOLID on the next clock regardless of frame position; counter cleared.
REQ-029 Blink state changes otherwise occur only at frame boundaries, never mid-frame.

Reset
REQ-030 On reset: shift registers and *_out = 0, rgb = 12'h000, pal_pending = 0, FSM = SOLID, counter = 0, edge-detect previous value = 1.
REQ-031 On reset both banks load: [0]=FFF, [1]=000, [2]=F00, [3]=00F, [4]=000, [5]=0F0, [6]=FF0, [7]=F0F.
REQ-032 Reset mid-frame or mid-blink discards pending writes and returns all state to REQ-030/031 values on the next clock.

Verification
REQ-033 After reset, video_on=1, world_pixel=2, icon=0 held -> rgb=F00 from 1 cycle after sampling; video_on_out rises SYNC_DLY+1 cycles after video_on.
REQ-034 world_pixel=0, icon=3, video_on=1 -> rgb=F0F; then delayed video_on=0 -> rgb=000 regardless of codes.
REQ-035 Write pal_addr=0, pal_data=123 mid-frame -> pal_pending=1, rgb for world 0 stays FFF until next delayed-vsync fall, then 123, pal_pending=0.
REQ-036 Write on the exact frame-boundary cycle -> not committed that boundary, pal_pending=1, committed at following boundary.
REQ-037 BLINK_FRAMES=2, blink_en=1, icon=1 over world 1 -> icon colour 0F0 frames 1-2, world colour 000 frames 3-4, 0F0 frames 5-6; drop blink_en in HIDE -> 0F0 next cycle.
REQ-038 Assert reset during HIDE with a pending write -> next cycle FSM SOLID, pal_pending=0, palette at REQ-031 values.
